serial_sub: RTL and testbench

SERIAL_SUB -- requirements
Module: serial_sub

---
 rtl/serial_sub.sv | 110 +++++++++++
 tb/tb_serial_sub.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b one bit pair per cycle, LSB first,
// and reports the difference and final borrow with a one-cycle done pulse.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for start; d/bout hold the last result
   // RUN   | one bit pair processed per cycle, WIDTH cycles
   // DONE  | result valid, done pulses for one cycle

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] res;
   logic             br;
   logic [CW-1:0]    cnt;

   logic diff;
   logic br_next;
   logic last;

   assign diff    = sh_a[0] ^ sh_b[0] ^ br;
   assign br_next = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & br);
   assign last    = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The result register is only touched in RUN, so it naturally holds the
   // finished difference through DONE and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a <= '0;
         sh_b <= '0;
         res  <= '0;
         br   <= 1'b0;
         cnt  <= '0;
      end else begin
         if (state == IDLE && start) begin
            sh_a <= a;
            sh_b <= b;
            br   <= 1'b0;
            cnt  <= '0;
         end else if (state == RUN) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            res  <= {diff, res[WIDTH-1:1]};
            br   <= br_next;
            cnt  <= cnt + 1'b1;
         end
      end
   end

   assign d    = res;
   assign bout = br;

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub at WIDTH=8: expected {bout,d} pushed on
// start, popped and compared on every done pulse.
module tb_serial_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] d;
   logic         bout;
   logic         busy;
   logic         done;

   int n_cmp = 0;
   int n_err = 0;

   logic [W:0] sb_q[$];
   logic [W:0] exp_last;

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .d     (d),
      .bout  (bout),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
      logic [W:0] r;
      r = {1'b0, av} - {1'b0, bv};
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [W:0] e;
            e = sb_q.pop_front();
            check("result", 32'({bout, d}), 32'(e));
         end
         check("busy_with_done", 32'(busy), 32'd0);
      end
   end

   // Called at a negedge; returns at the negedge after the done cycle.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit chk_lat, input int glitch_cyc);
      int cyc;
      int nbusy;
      bit seen;
      a        = av;
      b        = bv;
      start    = 1'b1;
      exp_last = model(av, bv);
      sb_q.push_back(exp_last);
      cyc   = 0;
      nbusy = 0;
      seen  = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = (glitch_cyc != 0 && cyc == glitch_cyc);
         a     = W'($urandom);
         b     = W'($urandom);
         if (busy) nbusy++;
         if (done) seen = 1'b1;
      end
      check("done_timeout", 32'(seen), 32'd1);
      if (chk_lat) begin
         check("latency", 32'(cyc), 32'(W + 1));
         check("busy_cycles", 32'(nbusy), 32'(W));
      end
      @(negedge clk);
      check("hold_result", 32'({bout, d}), 32'(exp_last));
      check("idle_flags", 32'({busy, done}), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int gap;
      bit seen;

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({busy, done, bout, d}), 32'd0);

      // start presented on the same edge that reset release takes effect
      rst_n = 1'b1;
      run_op(8'h05, 8'h03, 1'b1, 0);

      run_op(8'h03, 8'h05, 1'b1, 0);
      run_op(8'h00, 8'h00, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 1'b0, 0);
      run_op(8'h00, 8'h01, 1'b0, 0);

      // start re-pulsed with scrambled operands during RUN must be ignored
      run_op(8'h05, 8'h03, 1'b1, 3);

      // reset in the middle of RUN
      a     = 8'h37;
      b     = 8'h12;
      start = 1'b1;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("busy_before_rst", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_async", 32'({busy, done, bout, d}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (W + 4) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      check("no_done_after_abort", 32'(seen), 32'd0);
      run_op(8'h80, 8'h01, 1'b1, 0);

      // start held high across two operations
      a     = 8'h10;
      b     = 8'h01;
      start = 1'b1;
      sb_q.push_back(model(8'h10, 8'h01));
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
      end
      check("b2b_first_timeout", 32'(seen), 32'd1);
      check("b2b_first_val", 32'({bout, d}), 32'h00F);
      a        = 8'h01;
      b        = 8'h10;
      exp_last = model(8'h01, 8'h10);
      sb_q.push_back(exp_last);
      gap  = 0;
      seen = 1'b0;
      while (!seen && gap < 40) begin
         @(negedge clk);
         gap++;
         if (busy) start = 1'b0;
         if (done) seen = 1'b1;
      end
      check("b2b_second_timeout", 32'(seen), 32'd1);
      check("b2b_period", 32'(gap), 32'(W + 2));
      check("b2b_second_val", 32'({bout, d}), 32'h1F1);
      @(negedge clk);
      check("b2b_idle_after", 32'({busy, done}), 32'd0);

      for (int i = 0; i < 1000; i++) begin
         run_op(W'($urandom), W'($urandom), 1'b0, 0);
      end

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
